// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
//
// Definitions shared by the UART receiver and transmitter: the frame FSM
// state encoding, the oversampling ratio, the majority-vote sample points
// within one bit period, and the tick at which a stop bit is decided.
// -----------------------------------------------------------------------------
package serial_pkg;

    // Frame-level FSM states. The transmitter walks the same sequence.
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } serial_state_t;

    // Ticks of the oversampling strobe per bit period.
    localparam int OVERSAMPLE  = 16;

    // Three samples around mid-bit feed the majority vote.
    localparam int SAMPLE_A    = 7;
    localparam int SAMPLE_B    = 8;
    localparam int SAMPLE_C    = 9;

    // The stop bit is decided at its last sample point, not at its end,
    // so a following start edge is never missed.
    localparam int STOP_DECIDE = 9;

endpackage

// File: rtl/serial_sync.sv
// -----------------------------------------------------------------------------
// serial_sync
//
// Two-flop synchronizer for a single asynchronous input. Both flops reset to
// RESET_VALUE (default 1, the idle level of a serial line), so leaving reset
// never produces a spurious edge on the synchronized output.
//
// Ports
//   CLK       input   destination clock
//   RST       input   asynchronous, active-high reset
//   async_in  input   raw asynchronous signal
//   sync_out  output  async_in delayed by two CLK cycles, metastability-filtered
// -----------------------------------------------------------------------------
module serial_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/serial_rx.sv
// -----------------------------------------------------------------------------
// serial_rx
//
// Asynchronous serial receiver, 16x oversampled. Recovers 8N1 frames
// (DATA_BITS payload bits, LSB first) and hands each byte to the host in a
// holding register with a full flag, a read-acknowledge and error flags.
//
// Build option
//   SERIAL_RX_PARITY_EN  when defined, an even-parity bit follows the data
//                        bits and is checked; otherwise PARITY_ERR is 0.
//
// Parameters
//   DATA_BITS   payload bits per frame, 5..8
//
// Ports
//   CLK         input   system clock
//   RST         input   asynchronous, active-high reset
//   TICK_16X    input   one-cycle strobe at 16x the baud rate
//   RXD         input   raw serial line, idle high
//   RD_ACK      input   one-cycle pulse: host consumed DATA
//   DATA        output  last accepted byte
//   RX_FULL     output  DATA holds an unread byte
//   FRAME_ERR   output  stop bit of the last accepted frame was low
//   PARITY_ERR  output  parity mismatch on the last accepted frame
//   OVERRUN     output  sticky: a frame was dropped because RX_FULL was set
// -----------------------------------------------------------------------------
module serial_rx
    import serial_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 TICK_16X,
    input  logic                 RXD,
    input  logic                 RD_ACK,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 RX_FULL,
    output logic                 FRAME_ERR,
    output logic                 PARITY_ERR,
    output logic                 OVERRUN
);

    localparam logic [3:0] CNT_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] CNT_A    = 4'(SAMPLE_A);
    localparam logic [3:0] CNT_B    = 4'(SAMPLE_B);
    localparam logic [3:0] CNT_C    = 4'(SAMPLE_C);
    localparam logic [3:0] CNT_STOP = 4'(STOP_DECIDE);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

    logic                 rxd_s;
    serial_state_t        state_q;
    serial_state_t        state_d;
    logic [3:0]           cnt_q;
    logic [2:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 samp_a_q;
    logic                 samp_b_q;
    logic                 samp_c_q;
    logic                 bit_vote;
    logic                 stop_vote;
    logic                 bit_end;
    logic                 frame_done;
    logic                 accept;

    serial_sync #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .CLK      (CLK),
        .RST      (RST),
        .async_in (RXD),
        .sync_out (rxd_s)
    );

    // Majority of the three mid-bit samples. The stop bit is decided at its
    // third sample point, so its vote takes the live synchronized line as
    // the third sample instead of a stored one.
    assign bit_vote  = (samp_a_q & samp_b_q) | (samp_a_q & samp_c_q) | (samp_b_q & samp_c_q);
    assign stop_vote = (samp_a_q & samp_b_q) | (samp_a_q & rxd_s)    | (samp_b_q & rxd_s);

    assign bit_end    = TICK_16X && (cnt_q == CNT_LAST);
    assign frame_done = TICK_16X && (state_q == S_STOP) && (cnt_q == CNT_STOP);
    assign accept     = !RX_FULL || RD_ACK;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every transition happens on a tick.
    always_comb begin
        state_d = state_q;
        if (TICK_16X) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxd_s) begin
                        state_d = S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = bit_vote ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if ((cnt_q == CNT_LAST) && (bit_idx_q == BIT_LAST)) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q == CNT_STOP) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Tick counter within a bit. It is held at zero in IDLE and cleared on
    // any return to IDLE, so START always begins counting from zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (TICK_16X) begin
            if ((state_q == S_IDLE) || (state_d == S_IDLE)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    // Mid-bit samples for the majority vote.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            samp_a_q <= 1'b1;
            samp_b_q <= 1'b1;
            samp_c_q <= 1'b1;
        end else if (TICK_16X && (state_q != S_IDLE)) begin
            if (cnt_q == CNT_A) begin
                samp_a_q <= rxd_s;
            end
            if (cnt_q == CNT_B) begin
                samp_b_q <= rxd_s;
            end
            if (cnt_q == CNT_C) begin
                samp_c_q <= rxd_s;
            end
        end
    end

    // Data shift register and bit index. Bits arrive LSB first and enter at
    // the MSB, so after DATA_BITS shifts the first bit sits at bit 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift_q   <= '0;
            bit_idx_q <= '0;
        end else if (bit_end) begin
            if (state_q == S_START) begin
                bit_idx_q <= '0;
            end else if (state_q == S_DATA) begin
                shift_q   <= {bit_vote, shift_q[DATA_BITS-1:1]};
                bit_idx_q <= bit_idx_q + 3'd1;
            end
        end
    end

    // Holding register and host handshake. A frame completing in the same
    // cycle as RD_ACK is loaded, since the host has just freed the register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DATA      <= '0;
            RX_FULL   <= 1'b0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
        end else if (frame_done) begin
            if (accept) begin
                DATA      <= shift_q;
                RX_FULL   <= 1'b1;
                FRAME_ERR <= !stop_vote;
            end else begin
                OVERRUN   <= 1'b1;
            end
        end else if (RD_ACK && RX_FULL) begin
            RX_FULL <= 1'b0;
            OVERRUN <= 1'b0;
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    logic parity_bad_q;
    logic parity_err_q;

    // Even parity: data bits plus parity bit must have an even number of ones.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            parity_bad_q <= 1'b0;
        end else if (bit_end && (state_q == S_PARITY)) begin
            parity_bad_q <= (^shift_q) ^ bit_vote;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            parity_err_q <= 1'b0;
        end else if (frame_done && accept) begin
            parity_err_q <= parity_bad_q;
        end
    end

    assign PARITY_ERR = parity_err_q;
`else
    assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_rx
//
// Self-checking bench for serial_rx. Frames are driven bit by bit on RXD at
// 64 CLK cycles per bit (TICK_16X every 4 cycles). A behavioural model of the
// host-visible registers is updated per frame and per acknowledge, and every
// DUT output is compared against it.
// -----------------------------------------------------------------------------
module tb_serial_rx;

    localparam int DATA_BITS = 8;
    localparam int BIT_NEGS  = 64;
    // Offset into the stop bit (in CLK cycles) of the frame decision, given
    // that every frame starts one cycle after a tick-phase boundary.
    localparam int DECIDE_OFS = 42;
`ifdef SERIAL_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       tick_16x;
    logic       rxd;
    logic       rd_ack;
    logic [7:0] data;
    logic       rx_full;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int neg_idx = 0;

    logic [7:0] m_data;
    logic       m_full;
    logic       m_ferr;
    logic       m_perr;
    logic       m_ovr;

    logic [7:0] r_val;
    logic       r_stop;
    logic       r_par;
    logic       r_ack;

    serial_rx #(
        .DATA_BITS (DATA_BITS)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .TICK_16X   (tick_16x),
        .RXD        (rxd),
        .RD_ACK     (rd_ack),
        .DATA       (data),
        .RX_FULL    (rx_full),
        .FRAME_ERR  (frame_err),
        .PARITY_ERR (parity_err),
        .OVERRUN    (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n falling edges, regenerating the 16x tick (1 cycle in 4).
    task automatic stepNeg(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            neg_idx++;
            tick_16x = ((neg_idx % 4) == 3);
        end
    endtask

    task automatic driveBit(input logic v);
        rxd = v;
        stepNeg(BIT_NEGS);
    endtask

    task automatic modelReset();
        m_data = 8'h00;
        m_full = 1'b0;
        m_ferr = 1'b0;
        m_perr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // Host-visible effect of a completed frame.
    task automatic modelFrame(input logic [7:0] v, input logic stop_bit,
                              input logic par_bit, input logic ack_same);
        if (!m_full || ack_same) begin
            m_data = v;
            m_full = 1'b1;
            m_ferr = !stop_bit;
            m_perr = PAR_EN ? ((^v) ^ par_bit) : 1'b0;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    // Send one complete frame; optionally pulse RD_ACK in the decision cycle.
    task automatic applyStimulus(input logic [7:0] v, input logic stop_bit,
                                 input logic par_bit, input logic ack_at_end);
        while ((neg_idx % 4) != 1) stepNeg(1);
        driveBit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) driveBit(v[i]);
        if (PAR_EN) driveBit(par_bit);
        rxd = stop_bit;
        if (ack_at_end) begin
            stepNeg(DECIDE_OFS);
            rd_ack = 1'b1;
            stepNeg(1);
            rd_ack = 1'b0;
            stepNeg(BIT_NEGS - DECIDE_OFS - 1);
        end else begin
            stepNeg(BIT_NEGS);
        end
        rxd = 1'b1;
        modelFrame(v, stop_bit, par_bit, ack_at_end);
    endtask

    task automatic applyAck();
        rd_ack = 1'b1;
        stepNeg(1);
        rd_ack = 1'b0;
        if (m_full) begin
            m_full = 1'b0;
            m_ovr  = 1'b0;
        end
        stepNeg(2);
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (data === m_data) else begin
            errors++;
            $error("[TB] FAIL %s DATA: got %0h want %0h", tag, data, m_data);
        end
        checks++;
        assert (rx_full === m_full) else begin
            errors++;
            $error("[TB] FAIL %s RX_FULL: got %0b want %0b", tag, rx_full, m_full);
        end
        checks++;
        assert (frame_err === m_ferr) else begin
            errors++;
            $error("[TB] FAIL %s FRAME_ERR: got %0b want %0b", tag, frame_err, m_ferr);
        end
        checks++;
        assert (parity_err === m_perr) else begin
            errors++;
            $error("[TB] FAIL %s PARITY_ERR: got %0b want %0b", tag, parity_err, m_perr);
        end
        checks++;
        assert (overrun === m_ovr) else begin
            errors++;
            $error("[TB] FAIL %s OVERRUN: got %0b want %0b", tag, overrun, m_ovr);
        end
    endtask

    initial begin
        rst      = 1'b1;
        tick_16x = 1'b0;
        rxd      = 1'b1;
        rd_ack   = 1'b0;
        modelReset();
        stepNeg(5);
        checkOutput("reset");
        rst = 1'b0;
        stepNeg(8);

        // Basic frame and acknowledge.
        applyStimulus(8'hA5, 1'b1, ^8'hA5, 1'b0);
        stepNeg(4);
        checkOutput("a5");
        applyAck();
        checkOutput("a5_ack");

        // False start: line low for 3 ticks only.
        while ((neg_idx % 4) != 1) stepNeg(1);
        rxd = 1'b0;
        stepNeg(12);
        rxd = 1'b1;
        stepNeg(100);
        checkOutput("false_start");
        applyStimulus(8'h3C, 1'b1, ^8'h3C, 1'b0);
        stepNeg(4);
        checkOutput("3c");
        applyAck();

        // Stop bit low: frame error, idle gap lets the receiver resettle.
        applyStimulus(8'h3C, 1'b0, ^8'h3C, 1'b0);
        stepNeg(128);
        checkOutput("frame_err");
        applyAck();
        checkOutput("frame_err_ack");

        // Back-to-back frames with no acknowledge: second is dropped.
        applyStimulus(8'h11, 1'b1, ^8'h11, 1'b0);
        applyStimulus(8'h22, 1'b1, ^8'h22, 1'b0);
        stepNeg(4);
        checkOutput("overrun");
        applyAck();
        checkOutput("overrun_ack");

        // Acknowledge in the exact cycle the second frame completes.
        applyStimulus(8'h11, 1'b1, ^8'h11, 1'b0);
        applyStimulus(8'h22, 1'b1, ^8'h22, 1'b1);
        stepNeg(4);
        checkOutput("ack_same_cycle");

        // Reset in the middle of data bit 4, then a clean frame.
        while ((neg_idx % 4) != 1) stepNeg(1);
        driveBit(1'b0);
        driveBit(1'b0);
        driveBit(1'b1);
        driveBit(1'b0);
        driveBit(1'b1);
        rxd = 1'b1;
        stepNeg(20);
        rst = 1'b1;
        stepNeg(3);
        modelReset();
        checkOutput("in_reset");
        rst = 1'b0;
        stepNeg(100);
        checkOutput("after_reset");
        applyStimulus(8'h5A, 1'b1, ^8'h5A, 1'b0);
        stepNeg(4);
        checkOutput("5a_after_reset");
        applyAck();

`ifdef SERIAL_RX_PARITY_EN
        applyStimulus(8'h01, 1'b1, 1'b0, 1'b0);
        stepNeg(4);
        checkOutput("parity_bad");
        applyAck();
        applyStimulus(8'h01, 1'b1, 1'b1, 1'b0);
        stepNeg(4);
        checkOutput("parity_good");
        applyAck();
`endif

        // Randomized frames, stop bits, parity bits and acknowledge timing.
        for (int k = 0; k < 10; k++) begin
            r_val  = 8'($urandom);
            r_stop = ($urandom_range(0, 3) != 0);
            r_par  = ($urandom_range(0, 2) == 0) ? ~(^r_val) : (^r_val);
            r_ack  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) applyAck();
            applyStimulus(r_val, r_stop, r_par, r_ack);
            if (!r_stop) stepNeg(128);
            else stepNeg(8);
            checkOutput($sformatf("rand%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_rx.md
# serial_rx

Asynchronous serial receiver for the UART path. Consumes the 16x oversampling strobe produced by the DDFS baud generator and the raw RXD line, and recovers 8N1 frames (optionally 8E1). Delivers each received byte in a holding register with a full flag, a read-acknowledge handshake, and error flags, for the host-side logic.

## Interface
- DATA_BITS, 8, payload bits per frame, LSB first; legal range 5..8
- CLK  input  1  system clock; all state changes on its rising edge
- RST  input  1  asynchronous, active-high reset
- TICK_16X  input  1  one-CLK-cycle strobe at 16x baud, synchronous to CLK
- RXD  input  1  raw serial line, idle high, asynchronous to CLK
- RD_ACK  input  1  one-cycle pulse: host has consumed DATA
- DATA  output  DATA_BITS  last accepted byte
- RX_FULL  output  1  DATA holds an unread byte
- FRAME_ERR  output  1  stop bit of the last accepted frame sampled low
- PARITY_ERR  output  1  parity mismatch on the last accepted frame
- OVERRUN  output  1  sticky: a frame completed while RX_FULL was set

## Operation
- RXD passes through a 2-FF synchronizer (rxd_s); it is sampled only on TICK_16X cycles.
- Per-bit tick counter cnt, 4 bits, 0..15, wraps. Samples are taken at cnt 7, 8 and 9. The bit value is the majority of the 3 samples.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on a tick with rxd_s=0, go to START with cnt=0.
- START: at cnt 15, if the majority is 1, it is a false start; return to IDLE without any output. Otherwise go to DATA with bit index 0.
- DATA: at cnt 15, shift the majority bit into the MSB of the shift register (LSB-first reception). After DATA_BITS bits, go to PARITY if enabled, otherwise to STOP.
- PARITY: at cnt 15, record the even-parity check result, then go to STOP.
- STOP: at cnt 9, decide the frame and return to IDLE. Ending the stop bit early allows back-to-back frames.
- Frame decision:
  - If RX_FULL=0, or RD_ACK is asserted in the same cycle: load DATA, set RX_FULL, and update FRAME_ERR (stop majority = 0) and PARITY_ERR.
  - Otherwise: discard the frame, set OVERRUN, and leave DATA and the error flags unchanged.
- RD_ACK with no frame decision in the same cycle: clear RX_FULL and OVERRUN. FRAME_ERR and PARITY_ERR hold until the next load.
- RD_ACK while RX_FULL=0 is ignored.
- RST at any point (including mid-frame) aborts the frame immediately; the FSM restarts in IDLE.

## Timing
- Reset values: DATA=0, RX_FULL=0, FRAME_ERR=0, PARITY_ERR=0, OVERRUN=0, FSM=IDLE, cnt=0.
- RXD to rxd_s latency: 2 CLK cycles.
- RX_FULL and DATA are valid on the CLK edge after the TICK_16X cycle where STOP has cnt=9.
- A frame occupies (1 + DATA_BITS + parity) × 16 + 10 ticks from start detection.
- Start-edge uncertainty: up to 1 tick + 2 CLK.
- TICK_16X held high on consecutive cycles counts as one tick per cycle; no pulse-width check is done.
- No combinational path from any input to any output.

## Configuration
- SERIAL_RX_PARITY_EN defined:
  - PARITY state is present.
  - Even parity is checked over the data bits plus the parity bit.
  - PARITY_ERR is set on mismatch.
- Not defined:
  - PARITY state is removed and DATA goes directly to STOP.
  - PARITY_ERR is tied to 0.
  - Frame length shrinks by 16 ticks.

## Structure
- Shared package serial_pkg holds:
  - FSM state enum
  - OVERSAMPLE=16
  - sample points SAMPLE_A/B/C = 7/8/9
  - STOP_DECIDE=9
- The package is reused by the transmitter.
- One sub-module, serial_sync: 2-FF synchronizer with an asynchronous active-high reset value of 1. It is reusable for other asynchronous inputs.
- Majority vote and FSM stay inline in serial_rx.

## Test plan
- TICK_16X every 4 CLK cycles; send 0xA5 as 8N1 → DATA=0xA5, RX_FULL=1, FRAME_ERR=0. Then RD_ACK → RX_FULL=0.
- RXD low for 3 ticks then high → FSM back in IDLE after START, RX_FULL stays 0. Then send 0x3C → DATA=0x3C.
- Send 0x3C with the stop bit low → DATA=0x3C, FRAME_ERR=1.
- Send 0x11 then 0x22 back-to-back without RD_ACK → DATA=0x11, OVERRUN=1. RD_ACK → RX_FULL=0, OVERRUN=0.
- RD_ACK pulsed in the exact cycle the second frame completes → DATA=0x22, RX_FULL=1, OVERRUN=0.
- With SERIAL_RX_PARITY_EN: send 0x01 with parity bit 0 → PARITY_ERR=1; send 0x01 with parity bit 1 → PARITY_ERR=0.
- Assert RST during data bit 4, then send 0x5A → outputs all 0 during reset, then DATA=0x5A with no errors.
